seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU.
- Single-cycle add/sub/logic/shift/rotate/negate/not, plus iterative signed Booth multiply and signed non-restoring divide.
- Shift/rotate amount is variable, taken from B.
- Start/busy/done handshake; drives the Z register pair (hi/lo) of the datapath.

---
 rtl/seq_alu.sv | 225 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU driving the datapath Z pair (z_hi/z_lo), with iterative signed
// Booth multiply and signed non-restoring divide. Define SEQ_ALU_RADIX4_MUL_EN for a radix-4 multiplier.
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             div_zero
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int HW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef SEQ_ALU_RADIX4_MUL_EN
    localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH / 2);
`else
    localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH);
`endif
    localparam logic [CW-1:0] DIV_ITERS = CW'(WIDTH);
    localparam logic [SHAMT_W:0] SH_FULL = (SHAMT_W + 1)'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [HW-1:0]    acc_hi;   // Booth partial product, or signed divide remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier being consumed, or dividend/quotient shift reg
    logic             booth_q;
    logic [HW-1:0]    opnd;     // sign-extended multiplicand, or divisor magnitude
    logic             neg_q;
    logic             neg_r;

    // Handshake: start is taken only on an edge where busy=0 and done=0 (state IDLE); a start
    // seen at any other edge is dropped. done is a single-cycle valid for z_hi/z_lo/div_zero.
    assign busy = (state == S_MUL) || (state == S_DIV);
    assign done = (state == S_DONE);

    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W:0]   rot_inv;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     dif_w;
    logic [WIDTH-1:0]   sc_hi;
    logic [WIDTH-1:0]   sc_lo;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    assign shamt = b_in[SHAMT_W-1:0];
    assign a_abs = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_abs = b_in[WIDTH-1] ? -b_in : b_in;

    always_comb begin
        sum_w   = {1'b0, a_in} + {1'b0, b_in};
        dif_w   = {1'b0, a_in} - {1'b0, b_in};
        rot_inv = SH_FULL - {1'b0, shamt};
        sc_hi   = '0;
        sc_lo   = '0;
        case (alu_op)
            OP_ADD:  begin sc_lo = sum_w[WIDTH-1:0]; sc_hi = {{(WIDTH-1){1'b0}}, sum_w[WIDTH]}; end
            OP_SUB:  begin sc_lo = dif_w[WIDTH-1:0]; sc_hi = {{(WIDTH-1){1'b0}}, dif_w[WIDTH]}; end
            OP_AND:  sc_lo = a_in & b_in;
            OP_OR:   sc_lo = a_in | b_in;
            OP_NOT:  sc_lo = ~a_in;
            OP_NEG:  sc_lo = -a_in;
            OP_SHR:  sc_lo = a_in >> shamt;
            OP_SHRA: sc_lo = $unsigned($signed(a_in) >>> shamt);
            OP_SHL:  sc_lo = a_in << shamt;
            // A shift by the full width yields zero, so shamt=0 returns A unchanged.
            OP_ROR:  sc_lo = (a_in >> shamt) | (a_in << rot_inv);
            OP_ROL:  sc_lo = (a_in << shamt) | (a_in >> rot_inv);
            default: ;
        endcase
    end

    logic [HW-1:0]    m_sum;
    logic [HW-1:0]    m_hi;
    logic [WIDTH-1:0] m_lo;
    logic             m_q;

    always_comb begin
        m_sum = acc_hi;
`ifdef SEQ_ALU_RADIX4_MUL_EN
        case ({acc_lo[1:0], booth_q})
            3'b001, 3'b010: m_sum = acc_hi + opnd;
            3'b011:         m_sum = acc_hi + {opnd[HW-2:0], 1'b0};
            3'b100:         m_sum = acc_hi - {opnd[HW-2:0], 1'b0};
            3'b101, 3'b110: m_sum = acc_hi - opnd;
            default:        m_sum = acc_hi;
        endcase
        m_hi = {{2{m_sum[HW-1]}}, m_sum[HW-1:2]};
        m_lo = {m_sum[1:0], acc_lo[WIDTH-1:2]};
        m_q  = acc_lo[1];
`else
        case ({acc_lo[0], booth_q})
            2'b01:   m_sum = acc_hi + opnd;
            2'b10:   m_sum = acc_hi - opnd;
            default: m_sum = acc_hi;
        endcase
        m_hi = {m_sum[HW-1], m_sum[HW-1:1]};
        m_lo = {m_sum[0], acc_lo[WIDTH-1:1]};
        m_q  = acc_lo[0];
`endif
    end

    logic [HW-1:0]    d_sh;
    logic [HW-1:0]    d_rn;
    logic [HW-1:0]    d_rf;
    logic [WIDTH-1:0] d_qn;
    logic [WIDTH-1:0] d_rmag;
    logic [WIDTH-1:0] d_quo;
    logic [WIDTH-1:0] d_rem;

    // Unsigned non-restoring divide on magnitudes; signs are applied in the final cycle.
    always_comb begin
        d_sh   = {acc_hi[HW-2:0], acc_lo[WIDTH-1]};
        d_rn   = acc_hi[HW-1] ? (d_sh + opnd) : (d_sh - opnd);
        d_qn   = {acc_lo[WIDTH-2:0], ~d_rn[HW-1]};
        d_rf   = d_rn[HW-1] ? (d_rn + opnd) : d_rn;
        d_rmag = d_rf[WIDTH-1:0];
        d_quo  = neg_q ? -d_qn : d_qn;
        d_rem  = neg_r ? -d_rmag : d_rmag;
    end

    logic unused_bits;
    assign unused_bits = ^{d_rf[HW-1:WIDTH], m_hi[HW-1:WIDTH]};

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            booth_q  <= 1'b0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            z_hi     <= '0;
            z_lo     <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    div_zero <= 1'b0;
                    case (alu_op)
                        OP_MUL: begin
                            acc_hi  <= '0;
                            acc_lo  <= b_in;
                            booth_q <= 1'b0;
                            opnd    <= {{2{a_in[WIDTH-1]}}, a_in};
                            cnt     <= MUL_ITERS;
                            state   <= S_MUL;
                        end
                        OP_DIV: if (b_in == '0) begin
                            z_hi     <= a_in;
                            z_lo     <= '1;
                            div_zero <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= a_abs;
                            opnd   <= {2'b00, b_abs};
                            neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            neg_r  <= a_in[WIDTH-1];
                            cnt    <= DIV_ITERS;
                            state  <= S_DIV;
                        end
                        default: begin
                            z_hi  <= sc_hi;
                            z_lo  <= sc_lo;
                            state <= S_DONE;
                        end
                    endcase
                end
                S_MUL: begin
                    acc_hi  <= m_hi;
                    acc_lo  <= m_lo;
                    booth_q <= m_q;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        z_hi  <= m_hi[WIDTH-1:0];
                        z_lo  <= m_lo;
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc_hi <= d_rn;
                    acc_lo <= d_qn;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        z_hi  <= d_rem;
                        z_lo  <= d_quo;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table, hand-built corner sequences and a randomized run
// checked against an arithmetic reference model through an expected-result queue.
module tb_seq_alu;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
`ifdef SEQ_ALU_RADIX4_MUL_EN
    localparam int MUL_LAT = 17;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clock;
    logic        clear;
    logic        start;
    logic [4:0]  alu_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        div_zero;

    seq_alu #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .alu_op(alu_op),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .z_hi(z_hi), .z_lo(z_lo), .div_zero(div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          pulse;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [64:0] exp_q[$];
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Reference model written from the arithmetic definitions of each opcode.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz, output int lat);
        longint sa, sb, p, q, r;
        logic [63:0] t;
        int sh;
        sa  = longint'(int'(a));
        sb  = longint'(int'(b));
        sh  = int'(b[4:0]);
        hi  = '0;
        lo  = '0;
        dz  = 1'b0;
        lat = 1;
        case (op)
            OP_ADD:  begin t = {32'b0, a} + {32'b0, b}; hi = t[63:32]; lo = t[31:0]; end
            OP_SUB:  begin lo = a - b; hi = (a < b) ? 32'd1 : 32'd0; end
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_NOT:  lo = ~a;
            OP_NEG:  lo = 32'd0 - a;
            OP_SHR:  lo = a >> sh;
            OP_SHRA: begin p = sa >>> sh; lo = p[31:0]; end
            OP_SHL:  lo = a << sh;
            OP_ROR:  begin t = {a, a} >> sh; lo = t[31:0]; end
            OP_ROL:  begin t = {a, a} << sh; lo = t[63:32]; end
            OP_MUL:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; lat = MUL_LAT; end
            OP_DIV: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0]; lat = DIV_LAT;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int elat, input int pulse);
        logic [64:0] e;
        int lat;
        bit seen;
        e = exp_q.pop_front();
        @(negedge clock);
        start = 1'b1; alu_op = op; a_in = a; b_in = b;
        @(posedge clock);
        #1;
        start = 1'b0; alu_op = 5'($urandom_range(0, 31)); a_in = $urandom; b_in = $urandom;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clock);
            lat++;
            if (done) seen = 1'b1;
            else if (lat == 1) begin
                check({tag, "_busy"}, 64'(busy), 64'd1);
                check({tag, "_zhold"}, {z_hi, z_lo}, {prev_hi, prev_lo});
            end
            if (pulse != 0 && lat == pulse) begin
                start = 1'b1; alu_op = OP_ADD; a_in = 32'd1; b_in = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hilo"}, {z_hi, z_lo}, e[63:0]);
        check({tag, "_dz"}, 64'(div_zero), 64'(e[64]));
        prev_hi = e[63:32];
        prev_lo = e[31:0];
        // A start presented during the done cycle must be dropped.
        start = 1'b1; alu_op = OP_ADD; a_in = 32'd5; b_in = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check({tag, "_no_restart"}, {62'd0, done, busy}, 64'd0);
        check({tag, "_zkeep"}, {z_hi, z_lo}, {prev_hi, prev_lo});
    endtask

    vec_t vecs[19];
    logic [4:0] rops[14];

    initial begin
        vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h1,        32'h1,        32'h0,        1'b0, 1,       0};
        vecs[1]  = '{OP_ROR,  32'h0000_00F1, 32'h4,        32'h0,        32'h1000_000F, 1'b0, 1,      0};
        vecs[2]  = '{OP_MUL,  32'hFFFF_FFF9, 32'h3,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT, 5};
        vecs[3]  = '{OP_DIV,  32'hFFFF_FFEF, 32'h5,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, DIV_LAT, 0};
        vecs[4]  = '{OP_DIV,  32'h9,         32'h0,        32'h9,        32'hFFFF_FFFF, 1'b1, 1,       0};
        vecs[5]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       32'h8000_0000, 1'b0, DIV_LAT, 0};
        vecs[6]  = '{OP_SUB,  32'h3,         32'h5,        32'h1,        32'hFFFF_FFFE, 1'b0, 1,       0};
        vecs[7]  = '{OP_SHRA, 32'h8000_0000, 32'h4,        32'h0,        32'hF800_0000, 1'b0, 1,       0};
        vecs[8]  = '{OP_ROL,  32'h8000_0001, 32'h1,        32'h0,        32'h0000_0003, 1'b0, 1,       0};
        vecs[9]  = '{OP_ROR,  32'h1234_5678, 32'h20,       32'h0,        32'h1234_5678, 1'b0, 1,       0};
        vecs[10] = '{OP_ROL,  32'hA5A5_0001, 32'h40,       32'h0,        32'hA5A5_0001, 1'b0, 1,       0};
        vecs[11] = '{OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,      1'b0, MUL_LAT, 0};
        vecs[12] = '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       32'h1,        1'b0, MUL_LAT, 0};
        vecs[13] = '{OP_DIV,  32'h7,         32'hFFFF_FFFE, 32'h1,       32'hFFFF_FFFD, 1'b0, DIV_LAT, 0};
        vecs[14] = '{5'b11111, 32'h1234,     32'h5678,     32'h0,        32'h0,        1'b0, 1,       0};
        vecs[15] = '{OP_NEG,  32'h1,         32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1,      0};
        vecs[16] = '{OP_SHL,  32'h1,         32'h1F,       32'h0,        32'h8000_0000, 1'b0, 1,      0};
        vecs[17] = '{OP_SHR,  32'h8000_0000, 32'h1F,       32'h0,        32'h1,        1'b0, 1,       0};
        vecs[18] = '{OP_NOT,  32'h0F0F_0F0F, 32'h0,        32'h0,        32'hF0F0_F0F0, 1'b0, 1,      0};
        rops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NEG, OP_SHR, OP_SHRA,
                 OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV, 5'b00000};

        // Clock/reset.
        clear = 1'b1; start = 1'b0; alu_op = '0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        check("reset_z", {z_hi, z_lo}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz", 64'(div_zero), 64'd0);
        prev_hi = '0;
        prev_lo = '0;

        for (int i = 0; i < 19; i++) begin
            exp_q.push_back({vecs[i].dz, vecs[i].hi, vecs[i].lo});
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].pulse);
        end

        // Clear while a multiply is in flight.
        begin
            int ndone;
            @(negedge clock);
            start = 1'b1; alu_op = OP_MUL; a_in = 32'hFFFF_FFF9; b_in = 32'h3;
            @(posedge clock);
            #1;
            start = 1'b0;
            repeat (10) @(negedge clock);
            clear = 1'b1;
            @(posedge clock);
            #1;
            clear = 1'b0;
            @(negedge clock);
            check("clr_z", {z_hi, z_lo}, 64'd0);
            check("clr_busy_done", {62'd0, busy, done}, 64'd0);
            check("clr_dz", 64'(div_zero), 64'd0);
            ndone = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clock);
                if (done) ndone++;
            end
            check("clr_no_done", 64'(ndone), 64'd0);
            prev_hi = '0;
            prev_lo = '0;
            exp_q.push_back({1'b0, 32'h0, 32'h5});
            run_op("clr_add", OP_ADD, 32'h2, 32'h3, 1, 0);
        end

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  op;
            logic [31:0] a, b, hi, lo;
            logic        dz;
            int          lat;
            op = rops[$urandom_range(0, 13)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            model(op, a, b, hi, lo, dz, lat);
            exp_q.push_back({dz, hi, lo});
            run_op($sformatf("rnd%0d_op%0h", n, op), op, a, b, lat, 0);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
